synch_fifo: RTL and testbench
=============================

SYNCH_FIFO -- requirements
Module: synch_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of entries; it SHALL be a power of two, at least 2.
REQ-002 The module SHALL have parameter AW, default 3, equal to log2(DEPTH); pointer and count width SHALL be AW+1 (4 by default).
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-005 The module SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port wr_en, input, 1 bit: write request for this cycle.
REQ-007 The module SHALL have port rd_en, input, 1 bit: read request for this cycle.
REQ-008 The module SHALL have port wr_ptr, output, AW+1 bits: write pointer; MSB is the wrap bit, low AW bits are the slot address.
REQ-009 The module SHALL have port rd_ptr, output, AW+1 bits: read pointer, in the same format as wr_ptr.
REQ-010 The module SHALL have port existed_entries, output, AW+1 bits: number of occupied entries, 0..DEPTH.
REQ-011 The module SHALL have port available_entries, output, AW+1 bits: number of free entries, 0..DEPTH.
REQ-012 The module SHALL have port full, output, 1 bit: high when existed_entries equals DEPTH.
REQ-013 The module SHALL have port empty, output, 1 bit: high when existed_entries equals 0.

Function
REQ-014 The block SHALL be a pointer and occupancy tracker only; it SHALL have no data storage or data ports.
REQ-015 A write SHALL be accepted when wr_en=1 and full=0, and SHALL be ignored when full=1.
REQ-016 A read SHALL be accepted when rd_en=1 and empty=0, and SHALL be ignored when empty=1.
REQ-017 An accepted write SHALL increment wr_ptr by 1 modulo 2^(AW+1) at the next rising edge.
REQ-018 An accepted read SHALL increment rd_ptr by 1 modulo 2^(AW+1) at the next rising edge.
REQ-019 When full=1 and both wr_en and rd_en are high, only the read SHALL be accepted; occupancy SHALL drop by 1.
REQ-020 When empty=1 and both wr_en and rd_en are high, only the write SHALL be accepted; occupancy SHALL rise by 1.
REQ-021 When neither full nor empty and both requests are high, both SHALL be accepted; existed_entries SHALL be unchanged and both pointers SHALL advance.
REQ-022 existed_entries SHALL equal (wr_ptr - rd_ptr) modulo 2^(AW+1).
REQ-023 available_entries SHALL equal DEPTH - existed_entries.
REQ-024 full SHALL be 1 when the address bits of the two pointers are equal and their MSBs differ.
REQ-025 empty SHALL be 1 when wr_ptr equals rd_ptr.
REQ-026 The pointers SHALL be the only state registers; existed_entries, available_entries, full and empty SHALL be combinational from them, valid in the same cycle as the pointers.
REQ-027 Pointer wrap from 2^(AW+1)-1 to 0 SHALL be seamless; all derived outputs SHALL stay correct across the wrap.

Reset
REQ-028 While rstn=0, both pointers SHALL clear immediately, independent of clk.
REQ-029 While rstn=0, the outputs SHALL be: wr_ptr=0, rd_ptr=0, existed_entries=0, available_entries=DEPTH, full=0, empty=1.
REQ-030 An assertion of rstn in the middle of operation SHALL discard all occupancy.
REQ-031 The first rising edge after rstn deasserts SHALL already honour wr_en and rd_en.

Structure
REQ-032 DEPTH, AW and the pointer width derivation SHALL live in the shared package synch_fifo_pkg.
REQ-033 A single sub-module, fifo_ptr, SHALL implement the pointer register with its enable and wrap; synch_fifo SHALL instantiate it twice (write and read).

Verification
REQ-034 Reset scenario: rstn pulsed low with no clock activity -> wr_ptr=0, rd_ptr=0, existed=0, available=8, empty=1, full=0.
REQ-035 Fill scenario: wr_en=1 for 14 cycles from empty -> full=1 after the 8th write; wr_ptr=8, rd_ptr=0, existed=8, available=0; the last 6 writes are ignored.
REQ-036 Simultaneous requests when full: wr_en=rd_en=1 for 5 cycles -> cycle 1 reads only (existed=7); then both advance; result rd_ptr=5, wr_ptr=12, existed=7.
REQ-037 Refill then drain: wr_en=1 for 10 cycles -> full after 1 write (wr_ptr=13); then rd_en=1 for 20 cycles -> empty after 8 reads (rd_ptr=13); later reads are ignored and the pointers do not move.
REQ-038 Wrap-around: 20 interleaved write/read cycles at 1-4 entries -> both pointers wrap 15->0; existed, full and empty stay correct every cycle.
REQ-039 Reset mid-operation: rstn low at existed=5 -> outputs return to the reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/synch_fifo_pkg.sv
// Shared sizing for the synch_fifo pointer/occupancy tracker.
// Pointers carry one extra wrap bit above the slot address.
package synch_fifo_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register: advances by one on inc, clears on async reset.
module fifo_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // Natural PW-bit overflow gives the seamless wrap through the MSB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/synch_fifo.sv
// Pointer and occupancy tracker for a DEPTH-entry synchronous FIFO (no data path).
// Only the two pointers are state; every status output is decoded from them.
module synch_fifo
  import synch_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [AW:0] wr_ptr,
  output logic [AW:0] rd_ptr,
  output logic [AW:0] existed_entries,
  output logic [AW:0] available_entries,
  output logic        full,
  output logic        empty
);

  localparam int PW = ptr_width(AW);

  logic wr_acc;
  logic rd_acc;

  // Request semantics: wr_en/rd_en are per-cycle requests; a write is taken
  // only while !full and a read only while !empty, both at the next rising edge.
  // With both requested, a full FIFO takes only the read and an empty one only
  // the write, so occupancy never overflows or underflows.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (wr_acc),
    .ptr  (wr_ptr)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (rd_acc),
    .ptr  (rd_ptr)
  );

  // Modulo subtraction stays correct across the pointer wrap.
  assign existed_entries   = wr_ptr - rd_ptr;
  assign available_entries = PW'(DEPTH) - existed_entries;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: tb/tb_synch_fifo.sv
// Self-checking bench for synch_fifo: directed scenarios with a queue-based
// scoreboard fed by an occupancy-count reference model.
module tb_synch_fifo;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rstn;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [3:0] existed_entries;
  logic [3:0] available_entries;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  // Expected vector: {wr_ptr, rd_ptr, existed, available, full, empty}
  logic [17:0] exp_q[$];

  logic [3:0] m_wr;
  logic [3:0] m_rd;

  synch_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .wr_en             (wr_en),
    .rd_en             (rd_en),
    .wr_ptr            (wr_ptr),
    .rd_ptr            (rd_ptr),
    .existed_entries   (existed_entries),
    .available_entries (available_entries),
    .full              (full),
    .empty             (empty)
  );

  // ---------------- clock / reset ----------------
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- model / scoreboard ----------------
  function automatic logic [17:0] model_vec();
    logic [3:0] cnt;
    cnt = m_wr - m_rd;
    return {m_wr, m_rd, cnt, 4'd8 - cnt, (cnt == 4'd8), (cnt == 4'd0)};
  endfunction

  task automatic check_field(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [17:0] exp);
    check_field({tag, ".wr_ptr"},    wr_ptr,              exp[17:14]);
    check_field({tag, ".rd_ptr"},    rd_ptr,              exp[13:10]);
    check_field({tag, ".existed"},   existed_entries,     exp[9:6]);
    check_field({tag, ".available"}, available_entries,   exp[5:2]);
    check_field({tag, ".full"},      {3'b000, full},      {3'b000, exp[1]});
    check_field({tag, ".empty"},     {3'b000, empty},     {3'b000, exp[0]});
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic w, input logic r);
    logic [3:0] cnt;
    wr_en = w;
    rd_en = r;
    cnt = m_wr - m_rd;
    if (w && cnt != 4'd8) m_wr = m_wr + 4'd1;
    if (r && cnt != 4'd0) m_rd = m_rd + 4'd1;
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    check_vec(tag, exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [17:0] reset_vec;
    logic        w;
    logic        r;
    logic [3:0]  cnt;
    reset_vec = {4'd0, 4'd0, 4'd0, 4'd8, 1'b0, 1'b1};
    wr_en = 1'b0;
    rd_en = 1'b0;
    m_wr  = 4'd0;
    m_rd  = 4'd0;

    // Reset pulse with the clock stopped
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1 check_vec("reset_noclk", reset_vec);
    #2 rstn = 1'b1;
    #1 check_vec("reset_release", reset_vec);
    clk_run = 1'b1;
    #2;

    // Fill: 14 writes from empty, last 6 ignored
    for (int i = 0; i < 14; i++) begin
      step("fill", 1'b1, 1'b0);
      if (i == 7) check_field("fill_full_at_8", {3'b000, full}, 4'd1);
    end
    check_vec("fill_end", {4'd8, 4'd0, 4'd8, 4'd0, 1'b1, 1'b0});

    // Both requests while full: first cycle read only, then both advance
    step("both_full_first", 1'b1, 1'b1);
    check_field("both_first_existed", existed_entries, 4'd7);
    for (int i = 0; i < 4; i++) step("both", 1'b1, 1'b1);
    check_vec("both_end", {4'd12, 4'd5, 4'd7, 4'd1, 1'b0, 1'b0});

    // Refill then drain
    for (int i = 0; i < 10; i++) step("refill", 1'b1, 1'b0);
    check_vec("refill_end", {4'd13, 4'd5, 4'd8, 4'd0, 1'b1, 1'b0});
    for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b1);
    check_vec("drain_end", {4'd13, 4'd13, 4'd0, 4'd8, 1'b0, 1'b1});

    // Empty with both requests: only the write is taken
    step("both_empty", 1'b1, 1'b1);
    check_vec("both_empty_end", {4'd14, 4'd13, 4'd1, 4'd7, 1'b0, 1'b1 & 1'b0});

    // Wrap-around: interleaved traffic held at 1..4 entries
    step("wrap_prefill", 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cnt = m_wr - m_rd;
      w = (cnt >= 4'd4) ? 1'b0 : 1'b1;
      r = (cnt <= 4'd1) ? 1'b0 : 1'($urandom_range(0, 1));
      step("wrap", w, r);
    end
    check_field("wrap_wr_wrapped", {3'b000, (m_wr < 4'd13)}, 4'd1);
    check_field("wrap_rd_wrapped", {3'b000, (m_rd < 4'd13)}, 4'd1);

    // Build occupancy up to 5, then reset mid-operation
    while (4'(m_wr - m_rd) < 4'd5) step("to_five", 1'b1, 1'b0);
    check_field("pre_reset_existed", existed_entries, 4'd5);
    #2 rstn = 1'b0;
    #1 check_vec("reset_async", reset_vec);
    m_wr = 4'd0;
    m_rd = 4'd0;
    wr_en = 1'b1;
    @(posedge clk);
    #1 check_vec("reset_held", reset_vec);
    #2 rstn = 1'b1;

    // First edge after release honours the requests
    step("post_reset_write", 1'b1, 1'b0);
    check_field("post_reset_wr_ptr", wr_ptr, 4'd1);
    step("post_reset_both", 1'b1, 1'b1);
    step("post_reset_read", 1'b0, 1'b1);
    check_vec("post_reset_end", {4'd2, 4'd2, 4'd0, 4'd8, 1'b0, 1'b1});

    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drained: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
